prt_scaler_coef_seq: RTL and testbench

//  Coefficient sequencer in front of prt_scaler_coef. On a start pulse it walks every coefficient index of the

---
 rtl/prt_scaler_pkg.sv | 32 +++
 rtl/prt_scaler_coef_seq_if.sv | 36 +++
 rtl/prt_scaler_coef_fifo.sv | 71 +++++++
 rtl/prt_scaler_coef_seq.sv | 136 +++++++++++++
 tb/tb_prt_scaler_coef_seq.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prt_scaler_pkg.sv
// Shared types and constants for the scaler coefficient path.
// Mode enum, per-mode coefficient counts, FIFO depth and ROM latency.
package prt_scaler_pkg;

  typedef enum logic [1:0] {
    MODE_3_2 = 2'd0,
    MODE_2_1 = 2'd1,
    MODE_3_1 = 2'd2,
    MODE_4_3 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int ROM_LAT    = 2;

  function automatic int coef_count(input logic [1:0] mode);
    int n;
    case (mode)
      MODE_3_2: n = 17;
      MODE_2_1: n = 3;
      MODE_3_1: n = 11;
      default:  n = 76;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/prt_scaler_coef_seq_if.sv
// Control, ROM and coefficient-stream bundle of the sequencer.
// slave is the sequencer view, master the surrounding logic.
interface prt_scaler_coef_seq_if #(
  parameter int P_MODE = 2,
  parameter int P_IDX  = 7,
  parameter int P_DAT  = 8
);
  logic [P_MODE-1:0]       CFG_MODE_IN;
  logic                    STR_IN;
  logic                    CLR_IN;
  logic                    BUSY_OUT;
  logic                    DONE_OUT;
  logic [P_MODE+P_IDX-1:0] ROM_SEL_OUT;
  logic [P_DAT-1:0]        ROM_DAT_IN;
  logic [P_DAT-1:0]        COEF_DAT_OUT;
  logic [P_IDX-1:0]        COEF_IDX_OUT;
  logic                    COEF_LAST_OUT;
  logic                    COEF_VLD_OUT;
  logic                    COEF_RDY_IN;

  modport slave (
    input  CFG_MODE_IN, STR_IN, CLR_IN,
    input  ROM_DAT_IN, COEF_RDY_IN,
    output BUSY_OUT, DONE_OUT, ROM_SEL_OUT,
    output COEF_DAT_OUT, COEF_IDX_OUT,
    output COEF_LAST_OUT, COEF_VLD_OUT
  );

  modport master (
    output CFG_MODE_IN, STR_IN, CLR_IN,
    output ROM_DAT_IN, COEF_RDY_IN,
    input  BUSY_OUT, DONE_OUT, ROM_SEL_OUT,
    input  COEF_DAT_OUT, COEF_IDX_OUT,
    input  COEF_LAST_OUT, COEF_VLD_OUT
  );
endinterface

// File: rtl/prt_scaler_coef_fifo.sv
// 4-deep first-word-fall-through buffer of {dat, idx, last}.
// Head is forced to zero while empty; clr empties it synchronously.
module prt_scaler_coef_fifo
  import prt_scaler_pkg::*;
#(
  parameter int P_IDX = 7,
  parameter int P_DAT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [P_DAT-1:0] wr_dat,
  input  logic [P_IDX-1:0] wr_idx,
  input  logic             wr_last,
  input  logic             rd_en,
  output logic [P_DAT-1:0] rd_dat,
  output logic [P_IDX-1:0] rd_idx,
  output logic             rd_last,
  output logic             vld,
  output logic [2:0]       cnt
);
  localparam int W  = P_DAT + P_IDX + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [W-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          rd, wr;

  assign vld = cnt_q != 3'd0;
  assign cnt = cnt_q;
  assign rd  = rd_en & vld;
  assign wr  = wr_en & ((cnt_q != DEPTH_C) | rd);

  assign {rd_dat, rd_idx, rd_last} = vld ? mem_q[rp_q] : '0;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q + 3'(wr) - 3'(rd);
    if (wr) begin
      mem_d[wp_q] = {wr_dat, wr_idx, wr_last};
      wp_d        = wp_q + AW'(1);
    end
    if (rd) rp_d = rp_q + AW'(1);
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prt_scaler_coef_seq.sv
// Walks all coefficient indices of a ratio mode through the ROM and
// realigns the 2-cycle read data with its index into a valid/ready stream.
module prt_scaler_coef_seq
  import prt_scaler_pkg::*;
#(
  parameter int P_MODE = 2,
  parameter int P_IDX  = 7,
  parameter int P_DAT  = 8
) (
  input logic                 CLK_IN,
  input logic                 RST_IN,
  prt_scaler_coef_seq_if.slave bus
);
  localparam int TW = P_IDX + 2;

  state_e                  st_q, st_d;
  logic [P_MODE-1:0]       mode_q, mode_d;
  logic [P_IDX-1:0]        idx_q, idx_d;
  logic [P_MODE+P_IDX-1:0] sel_q, sel_d;
  logic                    iss_vld_q, iss_vld_d;
  logic                    iss_last_q, iss_last_d;
  logic                    done0_q, done0_d;
  logic [TW-1:0]           tag_q [ROM_LAT];
  logic [TW-1:0]           tag_d [ROM_LAT];
  logic [TW-1:0]           tag_o;

  logic [P_IDX-1:0] cnt_w, str_cnt;
  logic [3:0]       used;
  logic             issue, last_iss, xfer;
  logic [P_DAT-1:0] f_dat;
  logic [P_IDX-1:0] f_idx;
  logic             f_last, f_vld;
  logic [2:0]       f_cnt;

  assign cnt_w    = P_IDX'(coef_count(2'(mode_q)));
  assign str_cnt  = P_IDX'(coef_count(2'(bus.CFG_MODE_IN)));
  assign last_iss = idx_q == cnt_w;
  assign xfer     = f_vld & bus.COEF_RDY_IN;
  assign tag_o    = tag_q[ROM_LAT-1];

  // Credits: buffered plus in-flight, less the entry leaving this cycle.
  always_comb begin
    used = 4'(f_cnt) + 4'(iss_vld_q) - 4'(xfer);
    for (int i = 0; i < ROM_LAT; i++) used = used + 4'(tag_q[i][TW-1]);
  end

  assign issue = (st_q == S_ISSUE) && !bus.CLR_IN &&
                 (used < 4'(FIFO_DEPTH));

  always_comb begin
    st_d       = st_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    iss_vld_d  = issue;
    iss_last_d = iss_last_q;
    done0_d    = 1'b0;
    tag_d[0]   = {iss_vld_q, iss_last_q, sel_q[P_IDX-1:0]};
    for (int i = 1; i < ROM_LAT; i++) tag_d[i] = tag_q[i-1];
    if (issue) begin
      sel_d      = {mode_q, idx_q};
      iss_last_d = last_iss;
      idx_d      = idx_q + P_IDX'(1);
    end
    unique case (st_q)
      S_IDLE: if (bus.STR_IN) begin
        mode_d = bus.CFG_MODE_IN;
        idx_d  = P_IDX'(1);
        if (str_cnt == '0) done0_d = 1'b1;
        else               st_d    = S_ISSUE;
      end
      S_ISSUE: if (issue && last_iss) st_d = S_DRAIN;
      S_DRAIN: if (xfer && f_last)    st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    if (bus.CLR_IN) begin
      st_d      = S_IDLE;
      mode_d    = mode_q;
      idx_d     = idx_q;
      done0_d   = 1'b0;
      iss_vld_d = 1'b0;
      for (int i = 0; i < ROM_LAT; i++) tag_d[i] = '0;
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      st_q       <= S_IDLE;
      mode_q     <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      iss_vld_q  <= 1'b0;
      iss_last_q <= 1'b0;
      done0_q    <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      st_q       <= st_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      iss_vld_q  <= iss_vld_d;
      iss_last_q <= iss_last_d;
      done0_q    <= done0_d;
      tag_q      <= tag_d;
    end
  end

  prt_scaler_coef_fifo #(
    .P_IDX(P_IDX),
    .P_DAT(P_DAT)
  ) u_fifo (
    .clk    (CLK_IN),
    .rst    (RST_IN),
    .clr    (bus.CLR_IN),
    .wr_en  (tag_o[TW-1]),
    .wr_dat (bus.ROM_DAT_IN),
    .wr_idx (tag_o[P_IDX-1:0]),
    .wr_last(tag_o[P_IDX]),
    .rd_en  (bus.COEF_RDY_IN),
    .rd_dat (f_dat),
    .rd_idx (f_idx),
    .rd_last(f_last),
    .vld    (f_vld),
    .cnt    (f_cnt)
  );

  assign bus.BUSY_OUT      = st_q != S_IDLE;
  assign bus.DONE_OUT      = done0_q |
    ((st_q == S_DRAIN) && xfer && f_last && !bus.CLR_IN);
  assign bus.ROM_SEL_OUT   = sel_q;
  assign bus.COEF_DAT_OUT  = f_dat;
  assign bus.COEF_IDX_OUT  = f_idx;
  assign bus.COEF_LAST_OUT = f_last;
  assign bus.COEF_VLD_OUT  = f_vld;

endmodule

// File: tb/tb_prt_scaler_coef_seq.sv
// Sequencer bench: 2-cycle ROM model plus an expected-stream queue
// built per mode from the coefficient table.
module tb_prt_scaler_coef_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prt_scaler_coef_seq_if #(.P_MODE(2), .P_IDX(7), .P_DAT(8)) bus ();

  prt_scaler_coef_seq #(.P_MODE(2), .P_IDX(7), .P_DAT(8)) dut (
    .CLK_IN(clk),
    .RST_IN(rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] dat;
    logic [6:0] idx;
    logic       last;
  } item_t;

  function automatic logic [7:0] rom_val(input logic [1:0] m,
                                         input logic [6:0] i);
    if (i == 7'd0) return 8'd0;
    if (m == 2'd1 && i == 7'd1)  return 8'd114;
    if (m == 2'd1 && i == 7'd2)  return 8'd64;
    if (m == 2'd1 && i == 7'd3)  return 8'd13;
    if (m == 2'd3 && i == 7'd41) return 8'd240;
    if (m == 2'd3 && i == 7'd76) return 8'd125;
    if (m == 2'd2 && i == 7'd1)  return 8'd255;
    if (m == 2'd2 && i == 7'd11) return 8'd23;
    return 8'((int'(m) * 53 + int'(i) * 29 + 11) % 251);
  endfunction

  // ROM: select captured on one edge, data out on the next
  logic [8:0] rom_a_q = '0;
  logic [7:0] rom_q   = '0;
  always @(posedge clk) begin
    rom_a_q <= bus.ROM_SEL_OUT;
    rom_q   <= rom_val(rom_a_q[8:7], rom_a_q[6:0]);
  end
  assign bus.ROM_DAT_IN = rom_q;

  int counts [4] = '{17, 3, 11, 76};
  item_t exp_q [$];
  int checks = 0, errors = 0;
  int edges = 0, t0 = 0;
  int issued = 0, xfers = 0, max_out = 0;
  int first_vld = -1, done_at = -1, done_seen = 0;
  logic [8:0]  sel_prev = '0;
  logic [8:0]  sel_a;
  logic        hold_p = 1'b0;
  logic [15:0] hold_v = '0;
  logic        last_busy, last_vld;
  logic        poke_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    item_t e;
    logic  x, exp_done;
    @(negedge clk);
    x = bus.COEF_VLD_OUT && bus.COEF_RDY_IN;
    if (hold_p) begin
      chk("hold_vld", 32'(bus.COEF_VLD_OUT), 32'd1);
      chk("hold_beat", 32'({bus.COEF_DAT_OUT, bus.COEF_IDX_OUT,
                            bus.COEF_LAST_OUT}), 32'(hold_v));
    end
    if (bus.ROM_SEL_OUT != sel_prev && bus.ROM_SEL_OUT != '0) issued++;
    sel_prev = bus.ROM_SEL_OUT;
    if (issued - xfers > max_out) max_out = issued - xfers;
    if (bus.COEF_VLD_OUT && first_vld < 0) first_vld = edges - t0;
    exp_done = 1'b0;
    if (x) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("coef_dat", 32'(bus.COEF_DAT_OUT), 32'(e.dat));
        chk("coef_idx", 32'(bus.COEF_IDX_OUT), 32'(e.idx));
        chk("coef_last", 32'(bus.COEF_LAST_OUT), 32'(e.last));
        exp_done = e.last && !bus.CLR_IN;
      end
    end
    chk("done", 32'(bus.DONE_OUT), 32'(exp_done));
    if (bus.DONE_OUT) begin
      done_seen++;
      done_at = edges - t0 + 1;
    end
    if (x) xfers++;
    hold_p    = bus.COEF_VLD_OUT && !bus.COEF_RDY_IN;
    hold_v    = {bus.COEF_DAT_OUT, bus.COEF_IDX_OUT, bus.COEF_LAST_OUT};
    last_busy = bus.BUSY_OUT;
    last_vld  = bus.COEF_VLD_OUT;
    if (poke_done && bus.DONE_OUT) begin
      bus.STR_IN      = 1'b1;
      bus.CFG_MODE_IN = 2'd3;
    end
    @(posedge clk);
    edges++;
    #1;
    if (poke_done) bus.STR_IN = 1'b0;
  endtask

  task automatic start(input int m);
    item_t e;
    bus.CFG_MODE_IN = 2'(m);
    bus.STR_IN      = 1'b1;
    for (int i = 1; i <= counts[m]; i++) begin
      e.dat  = rom_val(2'(m), 7'(i));
      e.idx  = 7'(i);
      e.last = (i == counts[m]);
      exp_q.push_back(e);
    end
    issued    = 0;
    xfers     = 0;
    max_out   = 0;
    first_vld = -1;
    done_at   = -1;
    t0        = edges + 1;
    step();
    bus.STR_IN = 1'b0;
  endtask

  task automatic run_done(input int budget, input logic rnd,
                          input string tag);
    int d0 = done_seen;
    int n  = 0;
    while (done_seen == d0 && n < budget) begin
      if (rnd) bus.COEF_RDY_IN = 1'($urandom % 2);
      step();
      n++;
    end
    chk({tag, "_done_once"}, 32'(done_seen - d0), 32'd1);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.BUSY_OUT), 32'd0);
    chk({tag, "_done"}, 32'(bus.DONE_OUT), 32'd0);
    chk({tag, "_sel"}, 32'(bus.ROM_SEL_OUT), 32'd0);
    chk({tag, "_vld"}, 32'(bus.COEF_VLD_OUT), 32'd0);
    chk({tag, "_dat"}, 32'(bus.COEF_DAT_OUT), 32'd0);
    chk({tag, "_idx"}, 32'(bus.COEF_IDX_OUT), 32'd0);
    chk({tag, "_last"}, 32'(bus.COEF_LAST_OUT), 32'd0);
  endtask

  initial begin
    bus.CFG_MODE_IN = 2'd0;
    bus.STR_IN      = 1'b0;
    bus.CLR_IN      = 1'b0;
    bus.COEF_RDY_IN = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: mode 1, ready held high
    start(1);
    run_done(40, 1'b0, "t1");
    chk("t1_first_vld", 32'(first_vld), 32'd4);
    chk("t1_total", 32'(done_at), 32'd7);
    step();
    chk("t1_busy_drop", 32'(last_busy), 32'd0);

    // 2: mode 3, 76 back-to-back
    start(3);
    run_done(200, 1'b0, "t2");
    chk("t2_total", 32'(done_at), 32'd80);
    chk("t2_max_out", 32'(max_out <= 4), 32'd1);
    step();

    // 3: mode 0, ready low for 20 cycles after coef 1
    start(0);
    for (int n = 0; n < 20 && xfers < 1; n++) step();
    bus.COEF_RDY_IN = 1'b0;
    repeat (5) step();
    sel_a = sel_prev;
    repeat (15) step();
    chk("t3_sel_frozen", 32'(sel_prev), 32'(sel_a));
    chk("t3_sel_val", 32'(sel_prev), 32'h005);
    chk("t3_held", 32'(issued - xfers), 32'd4);
    chk("t3_vld_held", 32'(last_vld), 32'd1);
    bus.COEF_RDY_IN = 1'b1;
    run_done(80, 1'b0, "t3");
    step();

    // 4: mode 2, random ready
    start(2);
    run_done(400, 1'b1, "t4");
    chk("t4_max_out", 32'(max_out <= 4), 32'd1);
    bus.COEF_RDY_IN = 1'b1;
    step();

    // 5: clear at coef 30 of mode 3, then a clean mode 1 run
    start(3);
    for (int n = 0; n < 200 && xfers < 29; n++) step();
    bus.CLR_IN = 1'b1;
    step();
    bus.CLR_IN = 1'b0;
    exp_q.delete();
    hold_p = 1'b0;
    repeat (6) step();
    chk("t5_vld_off", 32'(last_vld), 32'd0);
    chk("t5_busy_off", 32'(last_busy), 32'd0);
    bus.CFG_MODE_IN = 2'd1;
    bus.STR_IN      = 1'b1;
    bus.CLR_IN      = 1'b1;
    step();
    bus.STR_IN = 1'b0;
    bus.CLR_IN = 1'b0;
    step();
    chk("t5_clr_wins", 32'(last_busy), 32'd0);
    start(1);
    run_done(40, 1'b0, "t5");
    chk("t5_first_vld", 32'(first_vld), 32'd4);
    step();

    // 6: start while busy and on the done cycle are ignored
    start(1);
    bus.CFG_MODE_IN = 2'd3;
    bus.STR_IN      = 1'b1;
    step();
    bus.STR_IN = 1'b0;
    poke_done  = 1'b1;
    run_done(40, 1'b0, "t6");
    poke_done = 1'b0;
    chk("t6_total", 32'(done_at), 32'd7);
    repeat (2) step();
    chk("t6_busy_idle", 32'(last_busy), 32'd0);
    chk("t6_vld_idle", 32'(last_vld), 32'd0);

    // 6: asynchronous reset mid-stream
    start(3);
    repeat (10) step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    hold_p   = 1'b0;
    sel_prev = '0;
    start(1);
    run_done(40, 1'b0, "post_rst");
    chk("post_rst_total", 32'(done_at), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
